ex_mem_stage: RTL

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/mem_handshake.sv | 81 ++++++++
 rtl/ex_mem_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the execute/memory boundary: memory-handshake FSM
// states, ALU_Control opcodes and the default memory timeout.
package riscv_pkg;

  // Memory-handshake FSM states; ACCESS means a data-memory request is open.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Cycles an access may wait for Mem_Ready before it is abandoned.
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // ALU_Control opcodes produced by the ALU decoder.
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Word accesses need the two low address bits clear.
  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/mem_handshake.sv
// Data-memory request FSM with access timeout.
//
// Handshake: a request opens on start (IDLE only) and Mem_Req rises the next
// cycle. While Mem_Req=1, Mem_Addr/Mem_WData/Mem_We are held constant. The
// access completes in the cycle Mem_Ready=1 is seen with Mem_Req=1 (complete
// pulses combinationally in that cycle); Mem_Ready with no open request is
// ignored. With no Mem_Ready for TIMEOUT_CYCLES ACCESS cycles the request is
// dropped and Mem_Err latches until reset.
module mem_handshake
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_addr,
  input  logic [31:0] start_wdata,
  input  logic        Mem_Ready,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic        Mem_Err,
  output logic        complete,
  output logic        fsm_state
);

  // Counter value seen in the last permitted ACCESS cycle.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  mem_state_t state;
  logic [7:0] wait_cnt;

  assign fsm_state = state;
  assign complete  = (state == ACCESS) && Mem_Ready;

  // FSM, timeout counter and registered memory-side outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= 8'd0;
      Mem_Req   <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= 32'd0;
      Mem_WData <= 32'd0;
      Mem_Err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACCESS;
            wait_cnt  <= 8'd0;
            Mem_Req   <= 1'b1;
            Mem_We    <= start_we;
            Mem_Addr  <= start_addr;
            Mem_WData <= start_wdata;
          end
        end
        ACCESS: begin
          if (Mem_Ready) begin
            state   <= IDLE;
            Mem_Req <= 1'b0;
            Mem_We  <= 1'b0;
          end else if (wait_cnt == LAST_WAIT) begin
            state    <= IDLE;
            Mem_Req  <= 1'b0;
            Mem_We   <= 1'b0;
            Mem_Err  <= 1'b1;
            wait_cnt <= wait_cnt + 8'd1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: accepts one instruction per cycle from execute,
// launches data-memory accesses, resolves branches/jumps and produces the
// writeback record. Upstream transfer happens on EX_Valid & ~Stall & ~Flush;
// anything presented while Flush=1 is the wrong path and is dropped.
module ex_mem_stage
  import riscv_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EX_Valid,
  input  logic [31:0] ALU_Result,
  input  logic        Zero,
  input  logic [31:0] RD2,
  input  logic [4:0]  Rd_Addr,
  input  logic        Reg_Write,
  input  logic        Mem_Read,
  input  logic        Mem_Write,
  input  logic        Branch,
  input  logic        Branch_Ne,
  input  logic        Jump,
  input  logic [31:0] PC_Target,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic        Mem_Ready,
  input  logic [31:0] Mem_RData,
  output logic        WB_Valid,
  output logic        WB_Reg_Write,
  output logic [4:0]  WB_Rd,
  output logic [31:0] WB_Data,
  output logic        Stall,
  output logic        PC_Src,
  output logic        Flush,
  output logic [31:0] PC_Next,
  output logic        Mem_Err,
  output logic        Misaligned
);

  logic accept;
  logic is_mem;
  logic aligned;
  logic taken;
  logic mem_start;
  logic mem_complete;
  logic fsm_state;

  // Register context for the access in flight, used when it completes.
  logic [4:0] pend_rd;
  logic       pend_rw;
  logic       pend_load;

  assign accept    = EX_Valid && !Stall && !Flush;
  assign is_mem    = Mem_Read || Mem_Write;
  assign aligned   = is_word_aligned(ALU_Result[1:0]);
  assign taken     = Jump || (Branch && (Branch_Ne ? !Zero : Zero));
  assign mem_start = accept && is_mem && aligned;
  assign Stall     = (fsm_state == 1'(ACCESS));

  // Mem_Write wins when both memory bits are set, so the access is a store.
  mem_handshake #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_handshake (
    .clk        (clk),
    .reset      (reset),
    .start      (mem_start),
    .start_we   (Mem_Write),
    .start_addr (ALU_Result),
    .start_wdata(RD2),
    .Mem_Ready  (Mem_Ready),
    .Mem_Req    (Mem_Req),
    .Mem_We     (Mem_We),
    .Mem_Addr   (Mem_Addr),
    .Mem_WData  (Mem_WData),
    .Mem_Err    (Mem_Err),
    .complete   (mem_complete),
    .fsm_state  (fsm_state)
  );

  // Writeback record: non-memory results one cycle after accept, memory
  // results one cycle after completion; the pending context is captured at launch.
  always_ff @(posedge clk) begin
    if (reset) begin
      WB_Valid     <= 1'b0;
      WB_Reg_Write <= 1'b0;
      WB_Rd        <= 5'd0;
      WB_Data      <= 32'd0;
      pend_rd      <= 5'd0;
      pend_rw      <= 1'b0;
      pend_load    <= 1'b0;
    end else begin
      WB_Valid     <= 1'b0;
      WB_Reg_Write <= 1'b0;
      if (mem_complete) begin
        WB_Valid     <= 1'b1;
        WB_Reg_Write <= pend_rw;
        WB_Rd        <= pend_rd;
        if (pend_load) begin
          WB_Data <= Mem_RData;
        end
      end else if (accept && !is_mem) begin
        WB_Valid     <= 1'b1;
        WB_Reg_Write <= Reg_Write;
        WB_Rd        <= Rd_Addr;
        WB_Data      <= ALU_Result;
      end
      if (mem_start) begin
        pend_rd   <= Rd_Addr;
        pend_rw   <= Reg_Write && !Mem_Write;
        pend_load <= !Mem_Write;
      end
    end
  end

  // Redirect for one cycle after a taken branch/jump, plus sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      PC_Src     <= 1'b0;
      Flush      <= 1'b0;
      PC_Next    <= 32'd0;
      Misaligned <= 1'b0;
    end else begin
      PC_Src  <= accept && taken;
      Flush   <= accept && taken;
      PC_Next <= (accept && taken) ? PC_Target : 32'd0;
      if (accept && is_mem && !aligned) begin
        Misaligned <= 1'b1;
      end
    end
  end

endmodule
